// File: rtl/regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_sched
// Brief    : Write-port scheduler for a 15-entry, two-write-port register
//            file. Arbitrates ALU (A), load/base-writeback (B) and long
//            multiply (M, lo/hi pair) producers onto ports 3 and 0, diverts
//            R15 writes to the PC path, and exports a pending-register mask.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_sched #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset,      // asynchronous, active low
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [ADDR_WIDTH-1:0] m_addr_lo,
    input  logic [ADDR_WIDTH-1:0] m_addr_hi,
    input  logic [DATA_WIDTH-1:0] m_data_lo,
    input  logic [DATA_WIDTH-1:0] m_data_hi,
    output logic                  we3,
    output logic [ADDR_WIDTH-1:0] wa3,
    output logic [DATA_WIDTH-1:0] wd3,
    output logic                  we0,
    output logic [ADDR_WIDTH-1:0] wa0,
    output logic [DATA_WIDTH-1:0] wd0,
    output logic                  pc_we,
    output logic [DATA_WIDTH-1:0] pc_wd,
    output logic [14:0]           pending,
    output logic                  m_err
);

    // Fairness flag: 1 when the AB group won the most recent grant.
    logic                  r_last_ab;

    logic                  w_ab_any;
    logic                  w_m_grant;
    logic                  w_ab_grant;
    logic                  w_m_same;

    // Slot 3 carries A or M lo, slot 0 carries B or M hi.
    logic                  w_s3_v;
    logic [ADDR_WIDTH-1:0] w_s3_a;
    logic [DATA_WIDTH-1:0] w_s3_d;
    logic                  w_s0_v;
    logic [ADDR_WIDTH-1:0] w_s0_a;
    logic [DATA_WIDTH-1:0] w_s0_d;
    logic                  w_s3_pc;
    logic                  w_s0_pc;

    // Group arbitration: M wins when alone or when AB had the last turn.
    // Requests are refused while reset is asserted so nothing is half-taken.
    always_comb begin
        w_ab_any   = a_valid | b_valid;
        w_m_same   = (m_addr_lo == m_addr_hi);
        w_m_grant  = reset & m_valid & (~w_ab_any | r_last_ab);
        w_ab_grant = reset & ~w_m_grant & w_ab_any;
        m_ready    = w_m_grant;
        b_ready    = w_ab_grant & b_valid;
        // Same-address A/B: B goes first so A's later write is the final one.
        a_ready    = w_ab_grant & a_valid & ~(b_valid & (a_addr == b_addr));
    end

    // Map the granted requests onto the two slots.
    always_comb begin
        w_s3_v = 1'b0;
        w_s3_a = '0;
        w_s3_d = '0;
        w_s0_v = 1'b0;
        w_s0_a = '0;
        w_s0_d = '0;
        if (w_m_grant) begin
            w_s0_v = 1'b1;
            w_s0_a = m_addr_hi;
            w_s0_d = m_data_hi;
            // lo==hi collapses to a single hi write on port 0.
            if (!w_m_same) begin
                w_s3_v = 1'b1;
                w_s3_a = m_addr_lo;
                w_s3_d = m_data_lo;
            end
        end else begin
            if (a_ready) begin
                w_s3_v = 1'b1;
                w_s3_a = a_addr;
                w_s3_d = a_data;
            end
            if (b_ready) begin
                w_s0_v = 1'b1;
                w_s0_a = b_addr;
                w_s0_d = b_data;
            end
        end
        w_s3_pc = w_s3_v & (w_s3_a == PC_ADDR);
        w_s0_pc = w_s0_v & (w_s0_a == PC_ADDR);
    end

    // Register slot contents for one cycle; R15 goes to the PC path instead.
    // At most one slot can target R15 in a cycle, so the PC mux never collides.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we3       <= 1'b0;
            wa3       <= '0;
            wd3       <= '0;
            we0       <= 1'b0;
            wa0       <= '0;
            wd0       <= '0;
            pc_we     <= 1'b0;
            pc_wd     <= '0;
            m_err     <= 1'b0;
            r_last_ab <= 1'b0;
        end else begin
            we3   <= w_s3_v & ~w_s3_pc;
            wa3   <= (w_s3_v & ~w_s3_pc) ? w_s3_a : '0;
            wd3   <= (w_s3_v & ~w_s3_pc) ? w_s3_d : '0;
            we0   <= w_s0_v & ~w_s0_pc;
            wa0   <= (w_s0_v & ~w_s0_pc) ? w_s0_a : '0;
            wd0   <= (w_s0_v & ~w_s0_pc) ? w_s0_d : '0;
            pc_we <= w_s3_pc | w_s0_pc;
            pc_wd <= w_s0_pc ? w_s0_d : (w_s3_pc ? w_s3_d : '0);
            if (w_m_grant) begin
                r_last_ab <= 1'b0;
            end else if (w_ab_grant) begin
                r_last_ab <= 1'b1;
            end
            if (w_m_grant && w_m_same) begin
                m_err <= 1'b1;
            end
        end
    end

    // Pending mask: registers being written this cycle or still waiting.
    generate
        for (genvar i = 0; i < 15; i++) begin : g_pend
            localparam logic [ADDR_WIDTH-1:0] c_idx = ADDR_WIDTH'(i);
            assign pending[i] = (we3 & (wa3 == c_idx))
                              | (we0 & (wa0 == c_idx))
                              | (reset & a_valid & ~a_ready & (a_addr == c_idx))
                              | (reset & b_valid & ~b_ready & (b_addr == c_idx))
                              | (reset & m_valid & ~m_ready &
                                 ((m_addr_lo == c_idx) | (m_addr_hi == c_idx)));
        end
    endgenerate

    // Both ports must never write the same register in one cycle.
    p_no_dual_write: assert property (@(posedge clk) disable iff (!reset)
        !(we3 && we0 && (wa3 == wa0)));

endmodule
`default_nettype wire
